// File: rtl/rt_access_ctrl_if.sv
// rtl/rt_access_ctrl_if.sv - request-side bus between LiM request logic and the racetrack access controller
//
// Purpose: groups the single-word request/response handshake into one bundle.
// Signals:
//   req, we, tgt, addr, wdata   requester -> controller (req held until ack)
//   busy, ack, err, rdata       controller -> requester
// Modports: master = requester side, slave = controller side.
interface rt_access_ctrl_if #(
    parameter int AW = 8,
    parameter int W  = 32
);
    logic          req;
    logic          we;
    logic [1:0]    tgt;
    logic [AW-1:0] addr;
    logic [W-1:0]  wdata;
    logic          busy;
    logic          ack;
    logic          err;
    logic [W-1:0]  rdata;

    modport master (
        output req, we, tgt, addr, wdata,
        input  busy, ack, err, rdata
    );

    modport slave (
        input  req, we, tgt, addr, wdata,
        output busy, ack, err, rdata
    );
endinterface

// File: rtl/rt_access_ctrl.sv
// rtl/rt_access_ctrl.sv - racetrack array access controller: shortest-path shifting, write and timed read
//
// Purpose: turns one outstanding read/write request into word-line select, shift pulses,
// write enable and read current for the racetrack array, tracking the domain position of
// the data/mask/program track classes.
// Ports:
//   clk_i, rst_i          clock (rising edge), synchronous active-high reset
//   bus                   request bus (slave side): req/we/tgt/addr/wdata in, busy/ack/err/rdata out
//   word_lines_o          one-hot row select
//   shift_fwd_o/_bwd_o    per-class +1/-1 shift pulse, [0]=data [1]=mask [2]=program
//   wr_en_o, write_data_o per-class write enable and write data
//   rd_cur_o              per-class read current
//   r_data_i/_m_i/_p_i    array read-out buses for data/mask/program
module rt_access_ctrl #(
    parameter int Nb     = 32,
    parameter int Np     = 8,
    parameter int Nr     = 4,
    parameter int NMU    = 8,
    parameter int RD_LAT = 2,
    localparam int W     = Nr * NMU,
    localparam int RW    = $clog2(Nb),
    localparam int PW    = $clog2(Np),
    localparam int AW    = RW + PW
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    rt_access_ctrl_if.slave      bus,
    output logic [Nb-1:0]        word_lines_o,
    output logic [2:0]           shift_fwd_o,
    output logic [2:0]           shift_bwd_o,
    output logic [2:0]           wr_en_o,
    output logic [W-1:0]         write_data_o,
    output logic [2:0]           rd_cur_o,
    input  logic [W-1:0]         r_data_i,
    input  logic [W-1:0]         r_data_m_i,
    input  logic [W-1:0]         r_data_p_i
);
    localparam int CW = $clog2(RD_LAT + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_SHIFT_P, S_SHIFT_G, S_WRITE, S_READ, S_DONE
    } state_t;

    state_t         state_q, state_d;
    logic           we_q, we_d;
    logic [1:0]     tgt_q, tgt_d;
    logic [RW-1:0]  row_q, row_d;
    logic           inv_q, inv_d;
    logic           fwd_q, fwd_d;
    logic [PW:0]    cnt_q, cnt_d;      // shifts still to issue
    logic [CW-1:0]  rd_cnt_q, rd_cnt_d;
    logic [W-1:0]   wdata_q, wdata_d;
    logic [W-1:0]   rdata_q, rdata_d;
    logic [PW-1:0]  pos_q [3];
    logic [PW-1:0]  pos_d [3];

    logic [PW-1:0]  req_pos, cur_pos, delta;
    logic [2:0]     tgt_oh;
    logic [W-1:0]   sel_rdata;

    assign req_pos = bus.addr[PW-1:0];
    assign tgt_oh  = 3'b001 << tgt_q;

    always_comb begin
        case (bus.tgt)
            2'd1:    cur_pos = pos_q[1];
            2'd2:    cur_pos = pos_q[2];
            default: cur_pos = pos_q[0];
        endcase
        case (tgt_q)
            2'd1:    sel_rdata = r_data_m_i;
            2'd2:    sel_rdata = r_data_p_i;
            default: sel_rdata = r_data_i;
        endcase
    end

    // Modular difference; wraps naturally because Np is a power of two.
    assign delta = req_pos - cur_pos;

    always_comb begin
        state_d  = state_q;
        we_d     = we_q;
        tgt_d    = tgt_q;
        row_d    = row_q;
        inv_d    = inv_q;
        fwd_d    = fwd_q;
        cnt_d    = cnt_q;
        rd_cnt_d = rd_cnt_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        pos_d    = pos_q;

        case (state_q)
            S_IDLE: begin
                if (bus.req) begin
                    we_d    = bus.we;
                    tgt_d   = bus.tgt;
                    row_d   = bus.addr[AW-1:PW];
                    wdata_d = bus.wdata;
                    inv_d   = (bus.tgt == 2'd3);
                    // Half-way tie goes forward.
                    fwd_d   = ({1'b0, delta} <= (PW+1)'(Np / 2));
                    cnt_d   = fwd_d ? {1'b0, delta} : {1'b0, PW'(0) - delta};
                    if (inv_d)
                        state_d = S_DONE;
                    else if (delta == '0)
                        state_d = bus.we ? S_WRITE : S_READ;
                    else
                        state_d = S_SHIFT_P;
                end
            end
            S_SHIFT_P: begin
                for (int i = 0; i < 3; i++) begin
                    if (tgt_q == 2'(i))
                        pos_d[i] = fwd_q ? pos_q[i] + PW'(1) : pos_q[i] - PW'(1);
                end
                cnt_d   = cnt_q - (PW+1)'(1);
                state_d = S_SHIFT_G;
            end
            S_SHIFT_G: begin
                if (cnt_q != '0)
                    state_d = S_SHIFT_P;
                else
                    state_d = we_q ? S_WRITE : S_READ;
            end
            S_WRITE: state_d = S_DONE;
            S_READ: begin
                if (rd_cnt_q == CW'(RD_LAT - 1)) begin
                    rdata_d  = sel_rdata;
                    rd_cnt_d = '0;
                    state_d  = S_DONE;
                end else begin
                    rd_cnt_d = rd_cnt_q + CW'(1);
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= S_IDLE;
            we_q     <= 1'b0;
            tgt_q    <= 2'd0;
            row_q    <= '0;
            inv_q    <= 1'b0;
            fwd_q    <= 1'b0;
            cnt_q    <= '0;
            rd_cnt_q <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            for (int i = 0; i < 3; i++) pos_q[i] <= '0;
        end else begin
            state_q  <= state_d;
            we_q     <= we_d;
            tgt_q    <= tgt_d;
            row_q    <= row_d;
            inv_q    <= inv_d;
            fwd_q    <= fwd_d;
            cnt_q    <= cnt_d;
            rd_cnt_q <= rd_cnt_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            pos_q    <= pos_d;
        end
    end

    // Array drive decodes directly from the registered state, so a reset edge
    // silences every array output from the following cycle.
    always_comb begin
        word_lines_o = '0;
        shift_fwd_o  = '0;
        shift_bwd_o  = '0;
        wr_en_o      = '0;
        write_data_o = '0;
        rd_cur_o     = '0;
        if (state_q inside {S_SHIFT_P, S_SHIFT_G, S_WRITE, S_READ})
            word_lines_o = Nb'(1) << row_q;
        if (state_q == S_SHIFT_P) begin
            if (fwd_q) shift_fwd_o = tgt_oh;
            else       shift_bwd_o = tgt_oh;
        end
        if (state_q == S_WRITE) begin
            wr_en_o      = tgt_oh;
            write_data_o = wdata_q;
        end
        if (state_q == S_READ)
            rd_cur_o = tgt_oh;
    end

    assign bus.busy  = (state_q != S_IDLE);
    assign bus.ack   = (state_q == S_DONE);
    assign bus.err   = (state_q == S_DONE) && inv_q;
    assign bus.rdata = rdata_q;
endmodule

// File: tb/tb_rt_access_ctrl.sv
// tb/tb_rt_access_ctrl.sv - self-checking scoreboard bench for rt_access_ctrl
module tb_rt_access_ctrl;
    localparam int NB = 32, NP = 8, RD_LAT = 2, W = 32, AW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic [NB-1:0] word_lines;
    logic [2:0]    shift_fwd, shift_bwd, wr_en, rd_cur;
    logic [W-1:0]  write_data;
    logic [W-1:0]  r_data, r_data_m, r_data_p;

    rt_access_ctrl_if #(.AW(AW), .W(W)) bus ();

    rt_access_ctrl #(.Nb(NB), .Np(NP), .Nr(4), .NMU(8), .RD_LAT(RD_LAT)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .bus          (bus),
        .word_lines_o (word_lines),
        .shift_fwd_o  (shift_fwd),
        .shift_bwd_o  (shift_bwd),
        .wr_en_o      (wr_en),
        .write_data_o (write_data),
        .rd_cur_o     (rd_cur),
        .r_data_i     (r_data),
        .r_data_m_i   (r_data_m),
        .r_data_p_i   (r_data_p)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        inv;
        logic        we;
        logic [1:0]  tgt;
        int          row;
        logic [31:0] wd;
        int          k;
        logic        fwd;
        int          lat;
        logic [31:0] rdata;
    } exp_t;

    exp_t        sb[$];
    int          mpos[3];
    logic [31:0] m_rdata;
    int          n_cmp = 0;
    int          n_bad = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic run_req(input logic we, input logic [1:0] tgt, input int row,
                           input int pos, input logic [31:0] wd);
        exp_t e;
        int   delta, c, bad, np, op_end;
        logic got_ack;
        logic [2:0]    oh, e_sf, e_sb, e_we, e_rc;
        logic [NB-1:0] e_wl;
        logic [31:0]   e_wd;
        e.inv = (tgt == 2'd3); e.we = we; e.tgt = tgt; e.row = row; e.wd = wd;
        e.k = 0; e.fwd = 1'b1;
        if (!e.inv) begin
            delta = (pos - mpos[int'(tgt)]) & (NP - 1);
            if (delta != 0 && delta <= NP / 2) e.k = delta;
            else if (delta != 0) begin e.k = NP - delta; e.fwd = 1'b0; end
            mpos[int'(tgt)] = pos;
            if (!we) m_rdata = (tgt == 2'd0) ? r_data : (tgt == 2'd1) ? r_data_m : r_data_p;
        end
        e.lat   = e.inv ? 1 : (we ? 2 + 2 * e.k : 1 + 2 * e.k + RD_LAT);
        e.rdata = m_rdata;
        sb.push_back(e);

        @(negedge clk);
        bus.req = 1'b1; bus.we = we; bus.tgt = tgt; bus.wdata = wd;
        bus.addr = AW'((row << 3) | pos);
        @(posedge clk);
        c = 0; bad = 0; np = 0; got_ack = 1'b0;
        oh = 3'b001 << sb[0].tgt;
        op_end = sb[0].we ? 2 * sb[0].k + 1 : 2 * sb[0].k + RD_LAT;
        while (!got_ack && c < 100) begin
            @(negedge clk);
            c++;
            e_wl = (!sb[0].inv && c <= op_end) ? (NB'(1) << sb[0].row) : '0;
            e_sf = (!sb[0].inv && sb[0].fwd && (c % 2 == 1) && c <= 2 * sb[0].k - 1) ? oh : 3'b0;
            e_sb = (!sb[0].inv && !sb[0].fwd && (c % 2 == 1) && c <= 2 * sb[0].k - 1) ? oh : 3'b0;
            e_we = (!sb[0].inv && sb[0].we && c == 2 * sb[0].k + 1) ? oh : 3'b0;
            e_wd = (e_we != 0) ? sb[0].wd : 32'h0;
            e_rc = (!sb[0].inv && !sb[0].we && c > 2 * sb[0].k && c <= op_end) ? oh : 3'b0;
            if ({word_lines, shift_fwd, shift_bwd, wr_en, write_data, rd_cur, bus.busy, bus.ack}
                !== {e_wl, e_sf, e_sb, e_we, e_wd, e_rc, 1'b1, (c == sb[0].lat)})
                bad++;
            if ((shift_fwd | shift_bwd) != 0) np++;
            if (bus.ack === 1'b1) got_ack = 1'b1;
        end
        bus.req = 1'b0;
        e = sb.pop_front();
        chk("ack_lat", c, e.lat);
        chk("err", bus.err, e.inv);
        chk("cycle_outputs", bad, 0);
        chk("pulse_count", np, e.k);
        chk("rdata", bus.rdata, e.rdata);
        @(negedge clk);
        chk("idle_after", {bus.busy, bus.ack}, 2'b00);
    endtask

    initial begin
        int c;
        rst = 1'b1;
        bus.req = 1'b1; bus.we = 1'b1; bus.tgt = 2'd0; bus.addr = '0; bus.wdata = 32'hFFFF_FFFF;
        r_data = '0; r_data_m = '0; r_data_p = '0;
        for (int i = 0; i < 3; i++) mpos[i] = 0;
        m_rdata = '0;

        // 1. reset with req held
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", bus.busy, 1'b0);
        chk("rst_ack_err", {bus.ack, bus.err}, 2'b00);
        chk("rst_array", {word_lines, shift_fwd, shift_bwd, wr_en, rd_cur}, '0);
        chk("rst_wdata", write_data, '0);
        chk("rst_rdata", bus.rdata, '0);
        bus.req = 1'b0; rst = 1'b0;
        @(negedge clk);
        chk("no_accept", bus.busy, 1'b0);

        // 2. plain write, no shifts
        run_req(1'b1, 2'd0, 5, 0, 32'hA5A5_A5A5);
        // 3. mask read 0->3
        r_data_m = 32'h1234_5678;
        run_req(1'b0, 2'd1, 9, 3, 32'h0);
        // 4. mask 3->7 tie, 7->1 wrap, 1->6 backward, data untouched
        r_data_m = $urandom;
        run_req(1'b0, 2'd1, 31, 7, 32'h0);
        run_req(1'b1, 2'd1, 0, 1, $urandom);
        r_data_m = $urandom;
        run_req(1'b0, 2'd1, 17, 6, 32'h0);
        r_data = $urandom;
        run_req(1'b0, 2'd0, 3, 0, 32'h0);
        // program track both directions
        run_req(1'b1, 2'd2, 12, 2, $urandom);
        r_data_p = $urandom;
        run_req(1'b0, 2'd2, 20, 7, 32'h0);
        // 5. invalid target
        run_req(1'b1, 2'd3, 7, 4, 32'hDEAD_BEEF);
        run_req(1'b0, 2'd3, 1, 1, 32'h0);

        // 6. reset during the second pulse of a 3-shift read on the data track
        @(negedge clk);
        bus.req = 1'b1; bus.we = 1'b0; bus.tgt = 2'd0;
        bus.addr = AW'((4 << 3) | ((mpos[0] + 3) & (NP - 1)));
        @(posedge clk);
        for (c = 1; c <= 3; c++) @(negedge clk);
        chk("mid_pulse", shift_fwd, 3'b001);
        bus.req = 1'b0; rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("abort_array", {word_lines, shift_fwd, shift_bwd, wr_en, rd_cur}, '0);
        chk("abort_busy", bus.busy, 1'b0);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) mpos[i] = 0;
        m_rdata = '0;
        r_data = 32'hCAFE_F00D;
        run_req(1'b0, 2'd0, 8, 2, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
